// File: rtl/rose_pulse_gen.sv
// -----------------------------------------------------------------------------
// rose_pulse_gen
//
// Purpose:
//   Driver side of the rise-then-hold protocol. A rising edge on `a` starts a
//   registered pulse on `b` in the next cycle. The pulse stays high for a
//   programmable number of consecutive cycles, clamped to [MIN_LEN:MAX_LEN].
//   The block also reports completion, ignored triggers, clamped lengths and
//   keeps a count of completed pulses.
//
// Parameters:
//   MIN_LEN   minimum pulse length in cycles (1 <= MIN_LEN <= MAX_LEN)
//   MAX_LEN   maximum pulse length in cycles
//   LW        width of the length field
//
// Ports:
//   clk        in   1   single clock, all logic on posedge
//   rst        in   1   synchronous, active-high reset
//   a          in   1   trigger level; only its rising edge matters
//   len_i      in   LW  requested pulse length, sampled on the accepted rise
//   b          out  1   registered pulse output
//   done       out  1   one-cycle pulse in the first low cycle after a pulse
//   drop       out  1   one-cycle pulse when a rise is ignored (pulse active)
//   len_err    out  1   one-cycle pulse when the accepted len_i was clamped
//   pulse_cnt  out  16  completed pulse count, wraps 0xFFFF -> 0
//   chk_err    out  1   sticky self-check failure flag
//
// Configuration:
//   ROSE_PULSE_GEN_SELFCHK_EN  when defined, an independent monitor watches
//                              `b` and raises chk_err on a protocol violation.
//                              When undefined, chk_err is tied to 0.
// -----------------------------------------------------------------------------
module rose_pulse_gen #(
  parameter int MIN_LEN = 2,
  parameter int MAX_LEN = 4,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a,
  input  logic [LW-1:0] len_i,
  output logic          b,
  output logic          done,
  output logic          drop,
  output logic          len_err,
  output logic [15:0]   pulse_cnt,
  output logic          chk_err
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_PULSE = 1'b1
  } state_t;

  localparam logic [LW-1:0] MIN_L = LW'(MIN_LEN);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

  // ---------------------------------------------------------------------------
  // Registers and next-state wires
  // ---------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_next;
  logic          r_a_q;
  logic [LW-1:0] r_cnt;
  logic [LW-1:0] w_cnt_next;
  logic          r_b;
  logic          w_b_next;
  logic          r_done;
  logic          w_done_next;
  logic          r_drop;
  logic          w_drop_next;
  logic          r_len_err;
  logic          w_len_err_next;
  logic [15:0]   r_pulse_cnt;
  logic [15:0]   w_pulse_cnt_next;

  // ---------------------------------------------------------------------------
  // Edge detect and length clamp
  // ---------------------------------------------------------------------------
  logic          w_rise;
  logic          w_len_lo;
  logic          w_len_hi;
  logic [LW-1:0] w_len_clamped;
  logic          w_accept;

  // r_a_q resets to 0, so `a` already high right after reset is a rise.
  assign w_rise   = a & ~r_a_q;

  // Full-width unsigned compare: len_i == 0 falls below MIN_L and clamps up.
  assign w_len_lo = (len_i < MIN_L);
  assign w_len_hi = (len_i > MAX_L);

  always_comb begin
    w_len_clamped = len_i;
    if (w_len_lo) begin
      w_len_clamped = MIN_L;
    end else if (w_len_hi) begin
      w_len_clamped = MAX_L;
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_rise;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a_q       <= 1'b0;
      r_cnt       <= '0;
      r_b         <= 1'b0;
      r_done      <= 1'b0;
      r_drop      <= 1'b0;
      r_len_err   <= 1'b0;
      r_pulse_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_next;
      r_a_q       <= a;
      r_cnt       <= w_cnt_next;
      r_b         <= w_b_next;
      r_done      <= w_done_next;
      r_drop      <= w_drop_next;
      r_len_err   <= w_len_err_next;
      r_pulse_cnt <= w_pulse_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // r_cnt holds the number of high cycles still to come after the current
  // one, so it is loaded with L-1 and the pulse ends when it reads zero.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_b_next         = r_b;
    w_done_next      = 1'b0;
    w_drop_next      = 1'b0;
    w_len_err_next   = 1'b0;
    w_pulse_cnt_next = r_pulse_cnt;

    case (r_state)
      S_IDLE: begin
        w_b_next = 1'b0;
        if (w_rise) begin
          w_state_next   = S_PULSE;
          w_b_next       = 1'b1;
          w_cnt_next     = w_len_clamped - LW'(1);
          w_len_err_next = w_len_lo | w_len_hi;
        end
      end

      S_PULSE: begin
        w_b_next = 1'b1;
        // A rise while busy is reported and otherwise ignored, including a
        // rise in the terminal cycle of the pulse.
        if (w_rise) begin
          w_drop_next = 1'b1;
        end
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - LW'(1);
        end else begin
          w_state_next     = S_IDLE;
          w_b_next         = 1'b0;
          w_done_next      = 1'b1;
          w_pulse_cnt_next = r_pulse_cnt + 16'd1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_b_next     = 1'b0;
      end
    endcase
  end

  assign b         = r_b;
  assign done      = r_done;
  assign drop      = r_drop;
  assign len_err   = r_len_err;
  assign pulse_cnt = r_pulse_cnt;

  // ---------------------------------------------------------------------------
  // Optional protocol monitor
  // ---------------------------------------------------------------------------
`ifdef ROSE_PULSE_GEN_SELFCHK_EN
  localparam logic [LW:0] RUN_MIN = (LW+1)'(MIN_LEN);
  localparam logic [LW:0] RUN_LIM = (LW+1)'(MAX_LEN + 1);

  // r_run counts consecutive high samples of b and saturates at MAX_LEN+1,
  // which is already a violation. It only observes the output and the
  // accepted-trigger strobe, never the FSM counter.
  logic [LW:0] r_run;
  logic        r_acc_q;
  logic        r_chk_err;
  logic [LW:0] w_run_inc;

  assign w_run_inc = r_run + (LW+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run     <= '0;
      r_acc_q   <= 1'b0;
      r_chk_err <= 1'b0;
    end else begin
      r_acc_q <= w_accept;
      if (r_b) begin
        if (r_run != RUN_LIM) begin
          r_run <= w_run_inc;
        end
        if (w_run_inc == RUN_LIM) begin
          r_chk_err <= 1'b1;
        end
      end else begin
        if ((r_run != '0) && (r_run < RUN_MIN)) begin
          r_chk_err <= 1'b1;
        end
        r_run <= '0;
      end
      // The cycle after an accepted rise must already show b high.
      if (r_acc_q && !r_b) begin
        r_chk_err <= 1'b1;
      end
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_rose_pulse_gen.sv
module tb_rose_pulse_gen;

  localparam int MIN_LEN = 2;
  localparam int MAX_LEN = 4;
  localparam int LW      = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a   = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          b, done, drop, len_err, chk_err;
  logic [15:0]   pulse_cnt;

  int tests = 0;
  int fails = 0;

  rose_pulse_gen #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .LW(LW)) dut (
    .clk(clk), .rst(rst), .a(a), .len_i(len_i), .b(b), .done(done),
    .drop(drop), .len_err(len_err), .pulse_cnt(pulse_cnt), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  // Behavioural reference: a pulse accepted at edge acc_k with length acc_l
  // drives b high after edges acc_k .. acc_k+acc_l-1 and ends at edge
  // acc_k+acc_l, where done fires and the count advances.
  int n      = 0;
  int acc_k  = -1000;
  int acc_l  = 0;
  bit prev_a = 1'b0;
  int mcnt   = 0;
  bit exp_b, exp_done, exp_drop, exp_len_err;
  int accepted = 0;

  function automatic int clamp_len(input int li);
    if (li < MIN_LEN) return MIN_LEN;
    if (li > MAX_LEN) return MAX_LEN;
    return li;
  endfunction

  function automatic logic [20:0] exp_vec();
    return {exp_b, exp_done, exp_drop, exp_len_err, 1'b0, 16'(mcnt)};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {b, done, drop, len_err, chk_err, pulse_cnt};
  endfunction

  // Drive one cycle of inputs, advance the model, settle 1 time unit after
  // the edge so outputs are observed away from the clock edge.
  task automatic step(input bit ai, input int li, input bit ri);
    bit rise, in_pulse;
    @(negedge clk);
    a = ai; len_i = LW'(li); rst = ri;
    @(posedge clk);
    n++;
    if (ri) begin
      prev_a = 1'b0; acc_k = -1000; acc_l = 0; mcnt = 0;
      exp_b = 0; exp_done = 0; exp_drop = 0; exp_len_err = 0;
    end else begin
      rise     = ai && !prev_a;
      prev_a   = ai;
      in_pulse = (n > acc_k) && (n <= acc_k + acc_l);
      exp_done = in_pulse && (n == acc_k + acc_l);
      if (exp_done) mcnt = (mcnt + 1) % 65536;
      exp_drop    = in_pulse && rise;
      exp_len_err = 1'b0;
      if (!in_pulse && rise) begin
        acc_k = n;
        acc_l = clamp_len(li);
        exp_len_err = (li < MIN_LEN) || (li > MAX_LEN);
        accepted++;
      end
      exp_b = (n >= acc_k) && (n < acc_k + acc_l);
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 1);
    step(0, 0, 1);
    tests++;
    if (dut_vec() !== 21'd0) begin
      fails++;
      $display("FAIL reset_state: got %h required %h", dut_vec(), 21'd0);
    end
    $display("[TB] reset: outputs=%h", dut_vec());
  endtask

  task automatic test_basic();
    bit [3:0] bh;
    step(0, 3, 1);
    for (int i = 0; i < 4; i++) step(0, 3, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 3, 0);
      bh[i] = b;
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL basic_model cyc%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (bh !== 4'b0111 || done !== 1'b1 || pulse_cnt !== 16'd1 || chk_err !== 1'b0) begin
      fails++;
      $display("FAIL basic_pulse: got b=%b done=%b cnt=%0d chk=%b required b=0111 done=1 cnt=1 chk=0",
               {bh[0], bh[1], bh[2], bh[3]}, done, pulse_cnt, chk_err);
    end
    $display("[TB] basic: len=3 b_hist=%b cnt=%0d", {bh[0], bh[1], bh[2], bh[3]}, pulse_cnt);
  endtask

  task automatic test_clamp();
    int lens[4]  = '{0, 7, 2, 4};
    int want[4]  = '{2, 4, 2, 4};
    bit werr[4]  = '{1, 1, 0, 0};
    for (int t = 0; t < 4; t++) begin
      int hi_cnt = 0;
      bit err_seen = 0;
      step(0, lens[t], 0);
      for (int i = 0; i < 7; i++) begin
        step(i == 0, lens[t], 0);
        if (b) hi_cnt++;
        if (i == 0) err_seen = len_err;
        tests++;
        if (dut_vec() !== exp_vec()) begin
          fails++;
          $display("FAIL clamp_model len=%0d cyc%0d: got %h required %h", lens[t], i, dut_vec(), exp_vec());
        end
      end
      tests++;
      if (hi_cnt != want[t] || err_seen !== werr[t]) begin
        fails++;
        $display("FAIL clamp len=%0d: got len=%0d err=%b required len=%0d err=%b",
                 lens[t], hi_cnt, err_seen, want[t], werr[t]);
      end
      $display("[TB] clamp: len_i=%0d pulse=%0d len_err=%b", lens[t], hi_cnt, err_seen);
    end
  endtask

  task automatic test_back_to_back();
    bit apat[8] = '{1, 0, 1, 0, 0, 1, 1, 0};
    bit bobs[8];
    bit dobs[8];
    step(0, 4, 1);
    step(0, 4, 0);
    for (int i = 0; i < 8; i++) begin
      step(apat[i], 4, 0);
      bobs[i] = b;
      dobs[i] = drop;
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL retrigger_model cyc%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (dobs[2] !== 1'b1 || bobs[3] !== 1'b1 || bobs[4] !== 1'b0 || bobs[5] !== 1'b1) begin
      fails++;
      $display("FAIL retrigger: got drop=%b b3=%b b4=%b b5=%b required 1 1 0 1",
               dobs[2], bobs[3], bobs[4], bobs[5]);
    end
    $display("[TB] retrigger: drop=%b restart_b=%b cnt=%0d", dobs[2], bobs[5], pulse_cnt);
  endtask

  task automatic test_level_hold();
    int rises = 0;
    bit last_b = 0;
    step(0, 3, 1);
    step(0, 3, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 3, 0);
      if (b && !last_b) rises++;
      last_b = b;
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL level_model cyc%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (rises != 1 || pulse_cnt !== 16'd1) begin
      fails++;
      $display("FAIL level_hold: got pulses=%0d cnt=%0d required 1 1", rises, pulse_cnt);
    end
    $display("[TB] level_hold: pulses=%0d cnt=%0d", rises, pulse_cnt);
  endtask

  task automatic test_reset_mid_pulse();
    step(0, 4, 1);
    step(0, 4, 0);
    step(1, 4, 0);
    step(1, 4, 0);
    step(1, 4, 1);
    tests++;
    if (b !== 1'b0 || done !== 1'b0 || pulse_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid: got b=%b done=%b cnt=%0d required 0 0 0", b, done, pulse_cnt);
    end
    step(1, 4, 0);
    tests++;
    if (b !== 1'b1 || dut_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL reset_restart: got %h required %h", dut_vec(), exp_vec());
    end
    $display("[TB] reset_mid: restart_b=%b cnt=%0d", b, pulse_cnt);
  endtask

  task automatic test_wrap();
    step(0, 2, 1);
    step(0, 2, 0);
    @(negedge clk);
    force dut.r_pulse_cnt = 16'hFFFF;
    #1;
    release dut.r_pulse_cnt;
    mcnt = 65535;
    for (int i = 0; i < 4; i++) begin
      step(i == 0, 2, 0);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL wrap_model cyc%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (pulse_cnt !== 16'd0) begin
      fails++;
      $display("FAIL wrap: got cnt=%0d required 0", pulse_cnt);
    end
    $display("[TB] wrap: cnt=%0d", pulse_cnt);
  endtask

  task automatic test_random();
    int errs = 0;
    int start_acc;
    bit ai = 0;
    step(0, 0, 1);
    start_acc = accepted;
    for (int i = 0; i < 4000; i++) begin
      bit ri;
      if ($urandom_range(0, 2) == 0) ai = ~ai;
      ri = ($urandom_range(0, 299) == 0);
      step(ai, int'($urandom_range(0, 7)), ri);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_model cyc%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
    end
    $display("[TB] random: 4000 cycles, %0d accepted triggers, mismatches=%0d", accepted - start_acc, errs);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_back_to_back();
    test_level_hold();
    test_reset_mid_pulse();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rose_pulse_gen.md
# rose_pulse_gen

- Generates the stimulus side of the rise-then-hold protocol: a rising edge on `a` produces a `b` pulse starting the next cycle.
- The pulse holds high for a programmable number of consecutive cycles bounded to [MIN_LEN:MAX_LEN].
- It is the driver counterpart to the `$rose(a) |=> b[*MIN:MAX]` checkers in our assertion suite and sits between a trigger source and any block expecting a bounded-length qualifier pulse.
- It reports completion, dropped triggers, clamped lengths and a completed-pulse count.

## Interface
- `MIN_LEN`, 2, minimum pulse length in cycles; legal range 1 ≤ MIN_LEN ≤ MAX_LEN.
- `MAX_LEN`, 4, maximum pulse length in cycles.
- `LW`, $clog2(MAX_LEN+1), width of the length field.
- `clk`  input  1  single clock; all logic on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `a`  input  1  trigger level; only its rising edge matters.
- `len_i`  input  LW  requested pulse length, sampled on the accepted rise.
- `b`  output  1  registered pulse output.
- `done`  output  1  one-cycle pulse in the first cycle `b` is low after a pulse.
- `drop`  output  1  one-cycle pulse when a rise is ignored because a pulse is active.
- `len_err`  output  1  one-cycle pulse when the accepted `len_i` was out of range and got clamped.
- `pulse_cnt`  output  16  count of completed pulses; wraps 0xFFFF→0.
- `chk_err`  output  1  sticky self-check failure flag (see Configuration).

## Operation
- Edge detect:
  - `a_q` registers `a`; reset value 0.
  - `rise = a & ~a_q`, combinational.
  - `a` already high in the first cycle after reset counts as a rise.
- FSM has two states.
  - IDLE: `b`=0. On `rise`, go to PULSE and set `b`<=1.
    - Load `cnt` <= L−1, where L = `len_i` clamped to [MIN_LEN, MAX_LEN].
    - Set `len_err`<=1 if `len_i` < MIN_LEN or `len_i` > MAX_LEN.
  - PULSE: `b`=1.
    - If `cnt`≠0: `cnt` decrements.
    - If `cnt`==0: go to IDLE, set `b`<=0 and `done`<=1, and increment `pulse_cnt`.
    - Any `rise` in PULSE sets `drop`<=1 and is otherwise ignored. This includes the terminal cycle.
- Arithmetic:
  - `cnt` is LW bits wide.
  - The clamp compares full-width unsigned values, so `len_i`=0 clamps to MIN_LEN.
- Back-to-back pulses: a rise sampled at the edge where `done` is visible is accepted normally. `b` therefore has at least one low cycle between pulses.
- Reset value of every output is 0 (`b`, `done`, `drop`, `len_err`, `pulse_cnt`, `chk_err`); state=IDLE, `cnt`=0, `a_q`=0.
- Reset mid-pulse:
  - `b` is low at the next edge.
  - No `done` is produced and `pulse_cnt` is not incremented.
  - The `rise` history is cleared.
- Length changes: `len_i` changes during PULSE have no effect.

## Timing
- All outputs are registered.
- For a rise sampled at edge k with clamped length L:
  - `b` is sampled high at edges k+1 … k+L.
  - `b` is sampled low at edge k+L+1, where `done`=1.
  - `pulse_cnt` shows the new value at edge k+L+1.
- `len_err` is sampled high at edge k+1 only.
- `drop` is sampled high at the edge after the ignored rise.
- Trigger-to-pulse latency is exactly 1 cycle, which satisfies `$rose(a) |=> b[*MIN_LEN:MAX_LEN]`.
- Maximum trigger rate: one accepted pulse per L+1 cycles.

## Configuration
- Macro `ROSE_PULSE_GEN_SELFCHK_EN`.
- Defined: an independent monitor compiled into the RTL.
  - It counts consecutive high samples of `b`.
  - It sets `chk_err` (sticky until `rst`) if any of the following occurs:
    - a high run ends with fewer than MIN_LEN samples;
    - a high run reaches MAX_LEN+1 samples;
    - `b` is low at the edge following an accepted rise.
- Undefined: the monitor is absent and `chk_err` is tied to 0. The port always exists.

## Test plan
- Basic: MIN=2, MAX=4, `len_i`=3, `a` 0→1 at edge 5.
  - Required: `b` high at edges 6–8, low at 9.
  - `done`=1 at 9, `pulse_cnt`=1, `len_err`=0, `chk_err`=0.
- Clamping:
  - `len_i`=0: 2-cycle pulse, `len_err`=1 at edge k+1.
  - `len_i`=7 (LW=3): 4-cycle pulse, `len_err`=1.
  - `len_i`=2 and `len_i`=4: no `len_err`.
- Retrigger: `len_i`=4, `a` toggles 0→1 at edge 10 and again at edge 12 (low at 11).
  - Required: one 4-cycle pulse at edges 11–14 and `drop`=1 at edge 13.
  - A rise at edge 15 (the `done` edge) is accepted, giving `b` high at 16.
- Level-held trigger: `a` held high for 20 cycles.
  - Required: exactly one pulse and `pulse_cnt`=1.
- Reset mid-pulse: `len_i`=4, rise at edge 5, `rst`=1 sampled at edge 7.
  - Required: `b`=0 from edge 8, no `done`, `pulse_cnt`=0, `a_q` cleared.
  - If `a` is still high after reset, a new pulse starts.
- Wrap and self-check:
  - Preload 65535 completed pulses via fast back-to-back triggers; the next completed pulse wraps `pulse_cnt` to 0.
  - With `ROSE_PULSE_GEN_SELFCHK_EN`, random `len_i` over 1000 triggers must leave `chk_err`=0.
